// File: rtl/mcse_pkg.sv
// Shared constants and types for the MTD3L host-side frame feeder.
// Stats counters exist only when MCSE_FEEDER_STATS_EN is defined.
package mcse_pkg;

  localparam int FRAME_W_DEF = 612;
  localparam int CNT_W_DEF   = 10;
  localparam int STATS_W     = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } feeder_state_t;

  function automatic logic [STATS_W-1:0] sat_inc(
    input logic [STATS_W-1:0] v
  );
    return (&v) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/mcse_frame_shifter.sv
// LSB-first frame shifter: holds the frame being sent and its bit count.
// Load has priority over the end-of-frame strobe so frames can run back-to-back.
module mcse_frame_shifter
  import mcse_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_load_data,
  input  logic               i_active,
  input  logic               i_data_req,
  output logic               o_data_in,
  output logic               o_data_in_valid,
  output logic               o_word_en,
  output logic               o_done
);

  logic [FRAME_W-1:0] r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_xfer;
  logic               w_last;

  assign w_xfer = i_active && i_data_req;
  assign w_last = (r_cnt == CNT_W'(FRAME_W - 1));

  assign o_data_in       = r_shreg[0];
  assign o_data_in_valid = w_xfer;
  assign o_word_en       = w_xfer && w_last;
  assign o_done          = w_xfer && w_last;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= i_load_data;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_shreg <= r_shreg >> 1;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mcse_frame_serializer.sv
// Double-buffered parallel-to-serial feeder for the MTD3L s2p input wrapper.
// Define MCSE_FEEDER_STATS_EN to add frames_sent / stall_cycles outputs.
module mcse_frame_serializer
  import mcse_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               data_req,
  output logic               data_in,
  output logic               data_in_valid,
  output logic               word_en,
`ifdef MCSE_FEEDER_STATS_EN
  output logic [STATS_W-1:0] frames_sent,
  output logic [STATS_W-1:0] stall_cycles,
`endif
  output logic               busy
);

  feeder_state_t      r_state;
  logic [FRAME_W-1:0] r_hold;
  logic               r_hold_full;
  logic               w_accept;
  logic               w_load;
  logic               w_done;
  logic               w_shift;

  assign w_shift  = (r_state == ST_SHIFT);
  assign w_accept = frame_valid && !r_hold_full;
  // Refill at end of frame keeps the serial stream gap-free.
  assign w_load   = r_hold_full && (!w_shift || w_done);

  assign frame_ready = !r_hold_full;
  assign busy        = w_shift || r_hold_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold      <= frame_in;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      case (r_state)
        ST_IDLE:  if (r_hold_full) r_state <= ST_SHIFT;
        ST_SHIFT: if (w_done && !r_hold_full) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  mcse_frame_shifter #(
    .FRAME_W (FRAME_W),
    .CNT_W   (CNT_W)
  ) u_shifter (
    .clk             (clk),
    .i_rst_n         (reset),
    .i_load          (w_load),
    .i_load_data     (r_hold),
    .i_active        (w_shift),
    .i_data_req      (data_req),
    .o_data_in       (data_in),
    .o_data_in_valid (data_in_valid),
    .o_word_en       (word_en),
    .o_done          (w_done)
  );

`ifdef MCSE_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frames_sent  <= '0;
      stall_cycles <= '0;
    end else begin
      if (word_en)
        frames_sent <= sat_inc(frames_sent);
      if (w_shift && !data_req)
        stall_cycles <= sat_inc(stall_cycles);
    end
  end
`endif

endmodule
